rice_core_branch_resolver: RTL
==============================

Name: rice_core_branch_resolver

Overview:
- Execute-stage block that resolves each instruction's actual control-flow outcome against the prediction carried down the pipeline from fetch.
- Produces the registered BRANCH_RESULT that trains the branch predictor's PHT/BTB and drives its hit/miss accounting.
- On a misprediction, issues a one-cycle flush and redirect PC to fetch, then discards wrong-path instructions for a fixed drain window.

Parameters:
- XLEN, 32, address/data width.
- FLUSH_CYCLES, 2, cycles of wrong-path discard after a flush (1..15).
- BRANCH_RESULT, logic, packed struct type with fields taken, not_taken, misprediction[1:0], pc[XLEN-1:0], target_pc[XLEN-1:0].

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_valid  input  1  instruction valid from decode/execute.
- o_ready  output  1  accept; `o_ready = !i_stall || (state == FLUSH)`.
- i_stall  input  1  downstream stall.
- i_pc  input  XLEN  instruction PC (bits [1:0] always 0).
- i_kind  input  2  0 = non-branch, 1 = conditional, 2 = JAL, 3 = JALR.
- i_cond_taken  input  1  ALU compare result; used only when i_kind == 1.
- i_target_pc  input  XLEN  computed target; for JALR, bit 0 is cleared internally.
- i_bp_taken  input  1  prediction taken, carried from fetch.
- i_bp_target_pc  input  XLEN  predicted target, carried from fetch.
- o_branch_result  output  $bits(BRANCH_RESULT)  registered result to the predictor.
- o_flush  output  1  one-cycle pipeline flush pulse.
- o_redirect_pc  output  XLEN  fetch restart PC; valid when o_flush = 1.

Behaviour:
- Clock and reset: i_clk is the single clock. i_rst_n is synchronous and active-low.
- Reset values: o_branch_result = 0, o_flush = 0, o_redirect_pc = 0, state = RUN, drain counter = 0.
- Accept condition: an instruction is accepted when `i_valid && o_ready`.
- Actual-taken (act):
  - i_kind 2 or 3: act = 1.
  - i_kind 1: act = i_cond_taken.
  - i_kind 0: act = 0.
- Actual target (tgt): i_target_pc, with bit 0 forced to 0 for JALR.
- Fall-through PC (ft): i_pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Misprediction bits:
  - dir_miss = `i_bp_taken != act`.
  - tgt_miss = `i_bp_taken && act && (i_bp_target_pc != tgt)`.
- Branch result, registered with latency 1 from accept; every accepted instruction in RUN writes o_branch_result:
  - taken = `act && (i_kind != 0)`.
  - not_taken = `(i_kind == 1) && !act`.
  - misprediction = {tgt_miss, dir_miss}.
  - pc = i_pc.
  - target_pc = tgt.
  - A predicted-taken non-branch gives taken = 0, not_taken = 0, misprediction[0] = 1.
- Idle result: any cycle without an accepted RUN instruction registers o_branch_result = 0. The result is therefore a single-cycle pulse and never repeats.
- Flush and redirect: if dir_miss or tgt_miss is set on an accept in RUN, then in the same registered cycle:
  - o_flush = 1.
  - o_redirect_pc = tgt if act, else ft.
  - o_flush deasserts the next cycle.
- FSM, states RUN and FLUSH:
  - RUN → FLUSH: on an accepted mispredicted instruction. Load drain counter = FLUSH_CYCLES.
  - FLUSH: o_ready = 1; i_valid is discarded, with no result and no flush. Counter decrements each cycle; at 1, next state is RUN.
  - A second misprediction cannot occur in FLUSH, because inputs are ignored there.
- Stall in RUN: with i_stall = 1, o_ready = 0, nothing is accepted, and the output result is 0.
- Reset mid-flush: returns to RUN and clears all outputs on the next edge.

Optional Feature:
- Macro: RICE_CORE_BRU_STATS_EN.
- When defined, adds ports:
  - o_branch_count  output  32
  - o_mispredict_count  output  32
- Counter rules:
  - o_branch_count increments on each accepted RUN instruction with i_kind != 0.
  - o_mispredict_count increments on each flush.
  - Both are saturating at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Correct not-taken: conditional, pc = 0x100, i_cond_taken = 0, i_bp_taken = 0 → next cycle not_taken = 1, misprediction = 0, o_flush = 0.
- Direction miss: conditional, pc = 0x200, tgt = 0x240, i_cond_taken = 1, i_bp_taken = 0 → taken = 1, misprediction = 2'b01, o_flush = 1, o_redirect_pc = 0x240. Then 2 cycles of o_ready = 1 with valid inputs dropped (result = 0). Then RUN.
- Target miss on JALR: pc = 0x300, i_target_pc = 0x501, bp target 0x400, bp taken → target_pc = 0x500, misprediction = 2'b10, o_redirect_pc = 0x500.
- False taken on non-branch: i_kind = 0, pc = 0xFFFF_FFFC, i_bp_taken = 1 → taken = 0, not_taken = 0, misprediction = 2'b01, o_redirect_pc = 0x0 (wrap).
- Stall/reset: i_stall = 1 with valid → o_ready = 0, no result. Assert i_rst_n = 0 during FLUSH → next edge all outputs 0, state RUN, o_ready = !i_stall.
- Stats (RICE_CORE_BRU_STATS_EN defined): 5 branches, 2 mispredicted → o_branch_count = 5, o_mispredict_count = 2.

Source files
------------

// File: rtl/rice_core_branch_resolver.sv
// Execute-stage branch resolver: compares the actual outcome against the fetch prediction, trains the predictor and issues flush/redirect.
// Optional statistics counters are enabled by defining RICE_CORE_BRU_STATS_EN.
module rice_core_branch_resolver #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_stall,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [1:0]          i_kind,
  input  logic                i_cond_taken,
  input  logic [XLEN-1:0]     i_target_pc,
  input  logic                i_bp_taken,
  input  logic [XLEN-1:0]     i_bp_target_pc,
  output logic [2*XLEN+3:0]   o_branch_result,
  output logic                o_flush,
  output logic [XLEN-1:0]     o_redirect_pc
`ifdef RICE_CORE_BRU_STATS_EN
  ,
  output logic [31:0]         o_branch_count,
  output logic [31:0]         o_mispredict_count
`endif
);

  // state | meaning
  // RUN   | resolving accepted instructions, one result per accept
  // FLUSH | draining wrong-path instructions for FLUSH_CYCLES cycles
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic            taken;
    logic            not_taken;
    logic [1:0]      misprediction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target_pc;
  } branch_result_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_COND = 2'd1;
  localparam logic [1:0] KIND_JAL  = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;

  localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES);

  state_t          state;
  logic [3:0]      drain_cnt;

  logic            act;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] ft;
  logic            dir_miss;
  logic            tgt_miss;
  logic            any_miss;
  logic            accept_run;
  branch_result_t  res_next;

  assign o_ready = !i_stall || (state == FLUSH);

  always_comb begin
    act = 1'b0;
    case (i_kind)
      KIND_COND: act = i_cond_taken;
      KIND_JAL:  act = 1'b1;
      KIND_JALR: act = 1'b1;
      default:   act = 1'b0;
    endcase

    tgt = i_target_pc;
    if (i_kind == KIND_JALR) tgt[0] = 1'b0;

    // Fall-through wraps naturally at the top of the address space.
    ft = i_pc + XLEN'(4);

    dir_miss   = (i_bp_taken != act);
    tgt_miss   = i_bp_taken && act && (i_bp_target_pc != tgt);
    any_miss   = dir_miss || tgt_miss;
    accept_run = i_valid && o_ready && (state == RUN);

    res_next               = '0;
    res_next.taken         = act && (i_kind != KIND_NONE);
    res_next.not_taken     = (i_kind == KIND_COND) && !act;
    res_next.misprediction = {tgt_miss, dir_miss};
    res_next.pc            = i_pc;
    res_next.target_pc     = tgt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= RUN;
      drain_cnt       <= '0;
      o_branch_result <= '0;
      o_flush         <= 1'b0;
      o_redirect_pc   <= '0;
    end else begin
      // Result, flush and redirect are single-cycle pulses unless reloaded below.
      o_branch_result <= '0;
      o_flush         <= 1'b0;
      o_redirect_pc   <= '0;
      case (state)
        RUN: begin
          if (accept_run) begin
            o_branch_result <= res_next;
            if (any_miss) begin
              o_flush       <= 1'b1;
              o_redirect_pc <= act ? tgt : ft;
              drain_cnt     <= DRAIN_LOAD;
              state         <= FLUSH;
            end
          end
        end
        FLUSH: begin
          drain_cnt <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef RICE_CORE_BRU_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (accept_run && (i_kind != KIND_NONE) && (o_branch_count != 32'hFFFF_FFFF))
        o_branch_count <= o_branch_count + 32'd1;
      if (accept_run && any_miss && (o_mispredict_count != 32'hFFFF_FFFF))
        o_mispredict_count <= o_mispredict_count + 32'd1;
    end
  end
`endif

endmodule
